// File: rtl/heap_cmd_issuer_if.sv
// heap_cmd_issuer_if: command, heap_control and snapshot-stream signals of heap_cmd_issuer
interface heap_cmd_issuer_if #(
    parameter int KEY_W = 32,
    parameter int IDX_W = 10
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_op;
    logic [KEY_W-1:0] cmd_key;
    logic             heap_start;
    logic             heap_op;
    logic [KEY_W-1:0] heap_key;
    logic             heap_done;
    logic [KEY_W-1:0] heap_arr_out;
    logic [IDX_W-1:0] heap_index;
    logic [IDX_W-1:0] heap_n;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [KEY_W-1:0] rsp_data;
    logic             rsp_last;
    logic             rsp_empty;
    modport master (
        input  cmd_valid, cmd_op, cmd_key, heap_done, heap_arr_out, heap_index, heap_n, rsp_ready,
        output cmd_ready, heap_start, heap_op, heap_key, rsp_valid, rsp_data, rsp_last, rsp_empty
    );
    modport slave (
        output cmd_valid, cmd_op, cmd_key, heap_done, heap_arr_out, heap_index, heap_n, rsp_ready,
        input  cmd_ready, heap_start, heap_op, heap_key, rsp_valid, rsp_data, rsp_last, rsp_empty
    );
endinterface

// File: rtl/heap_cmd_issuer.sv
// heap_cmd_issuer: queues push/pop commands, issues them to heap_control and replays the streamed heap snapshot
module heap_cmd_issuer #(
    parameter int KEY_W      = 32,
    parameter int IDX_W      = 10,
    parameter int CMDQ_DEPTH = 4,
    parameter int SNAP_DEPTH = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic              clk,
    input  logic              reset,
    heap_cmd_issuer_if.master bus,
    output logic              o_busy,
    output logic              o_err_timeout,
    output logic              o_err_trunc
);
    localparam int QW = $clog2(CMDQ_DEPTH);
    localparam int PW = QW + 1;
    localparam int SW = $clog2(SNAP_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_CAP = 3'd3, S_DRAIN = 3'd4;
    localparam logic [IDX_W-1:0] SD = IDX_W'(SNAP_DEPTH);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]       r_state;
    logic             r_q_op [CMDQ_DEPTH];
    logic [KEY_W-1:0] r_q_key [CMDQ_DEPTH];
    logic [PW-1:0]    r_wp, r_rp;
    logic [KEY_W-1:0] r_buf [SNAP_DEPTH];
    logic             r_op;
    logic [KEY_W-1:0] r_key;
    logic [IDX_W-1:0] r_len, r_exp, r_rd;
    logic [TW-1:0]    r_cnt;
    logic             r_empty, r_err_to, r_err_tr;
    logic             w_full, w_empty, w_wr, w_hit, w_last, w_drain, w_tmo;
    logic [IDX_W-1:0] w_beats;

    assign w_empty = r_wp == r_rp;
    assign w_full  = (r_wp ^ r_rp) == {1'b1, {QW{1'b0}}};
    assign w_wr    = bus.cmd_valid && !w_full;
    assign w_hit   = bus.heap_index == r_exp;
    assign w_tmo   = r_cnt == TO_LAST;
    assign w_drain = r_state == S_DRAIN;
    assign w_beats = (r_len > SD) ? SD : r_len;
    assign w_last  = r_empty || (r_rd == w_beats - IDX_W'(1));

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_q_op[r_wp[QW-1:0]]  <= bus.cmd_op;
            r_q_key[r_wp[QW-1:0]] <= bus.cmd_key;
        end
    end

    // Elements past SNAP_DEPTH are walked through but never stored.
    always_ff @(posedge clk) begin
        if (r_state == S_CAP && w_hit && r_exp < SD) r_buf[r_exp[SW-1:0]] <= bus.heap_arr_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_wp     <= '0;
            r_rp     <= '0;
            r_op     <= 1'b0;
            r_key    <= '0;
            r_len    <= '0;
            r_exp    <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_empty  <= 1'b0;
            r_err_to <= 1'b0;
            r_err_tr <= 1'b0;
        end else begin
            if (w_wr) r_wp <= r_wp + PW'(1);
            case (r_state)
                S_IDLE: if (!w_empty) begin
                    r_op    <= r_q_op[r_rp[QW-1:0]];
                    r_key   <= r_q_key[r_rp[QW-1:0]];
                    r_rp    <= r_rp + PW'(1);
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: if (bus.heap_done) begin
                    r_len   <= bus.heap_n;
                    r_exp   <= '0;
                    r_rd    <= '0;
                    r_cnt   <= '0;
                    r_empty <= bus.heap_n == '0;
                    if (bus.heap_n > SD) r_err_tr <= 1'b1;
                    r_state <= (bus.heap_n == '0) ? S_DRAIN : S_CAP;
                end else if (w_tmo) begin
                    r_err_to <= 1'b1;
                    r_state  <= S_IDLE;
                end else r_cnt <= r_cnt + TW'(1);
                // Only the expected index advances; junk and repeated indices fall through.
                S_CAP: if (w_hit) begin
                    r_exp <= r_exp + IDX_W'(1);
                    r_cnt <= '0;
                    if (r_exp + IDX_W'(1) == r_len) r_state <= S_DRAIN;
                end else if (w_tmo) begin
                    r_err_to <= 1'b1;
                    r_state  <= S_IDLE;
                end else r_cnt <= r_cnt + TW'(1);
                S_DRAIN: if (bus.rsp_ready) begin
                    if (w_last) begin
                        r_empty <= 1'b0;
                        r_state <= S_IDLE;
                    end else r_rd <= r_rd + IDX_W'(1);
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = !w_full;
    assign bus.heap_start = r_state == S_ISSUE && !reset;
    assign bus.heap_op    = r_op;
    assign bus.heap_key   = r_key;
    assign bus.rsp_valid  = w_drain;
    assign bus.rsp_data   = (w_drain && !r_empty) ? r_buf[r_rd[SW-1:0]] : '0;
    assign bus.rsp_last   = w_drain && w_last;
    assign bus.rsp_empty  = w_drain && r_empty;
    assign o_busy         = r_state != S_IDLE;
    assign o_err_timeout  = r_err_to;
    assign o_err_trunc    = r_err_tr;
endmodule

// File: tb/tb_heap_cmd_issuer.sv
// tb_heap_cmd_issuer: table-driven vectors plus directed corner sequences for heap_cmd_issuer
module tb_heap_cmd_issuer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy, err_to, err_tr;

    heap_cmd_issuer_if #(.KEY_W(32), .IDX_W(10)) bus();

    heap_cmd_issuer #(
        .KEY_W(32), .IDX_W(10), .CMDQ_DEPTH(4), .SNAP_DEPTH(16), .TIMEOUT(4096)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .o_busy(busy),
        .o_err_timeout(err_to),
        .o_err_trunc(err_tr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] key;
        int          n;
        int          lat;
        int          mode;
        bit          tgl;
        int          pat;
        logic [31:0] base;
        int          e_beats;
        bit          e_tr;
        bit          e_to;
    } vec_t;

    int checks = 0;
    int fails = 0;
    int cfg_n = 0, cfg_lat = 1, cfg_mode = 0, cfg_pat = 0;
    logic [31:0] cfg_base = 0;
    bit tgl = 0;
    bit streaming = 0;
    logic [31:0] pat3 [3] = '{32'd20, 32'd10, 32'd9};
    logic        st_op[$];
    logic [31:0] st_key[$];
    int          st_bt[$];
    logic [31:0] bq_d[$];
    logic        bq_l[$];
    logic        bq_e[$];
    int          beat_total = 0;
    vec_t        vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] dat(input int i);
        return (cfg_pat == 1) ? pat3[i] : cfg_base - 32'(i);
    endfunction

    // heap_control model: answers each start pulse with done, then streams the snapshot
    initial begin
        int iq[$];
        bus.heap_done = 1'b0;
        bus.heap_n = '0;
        bus.heap_index = '1;
        bus.heap_arr_out = '0;
        forever begin
            @(negedge clk);
            if (bus.heap_start) begin
                st_op.push_back(bus.heap_op);
                st_key.push_back(bus.heap_key);
                st_bt.push_back(beat_total);
                if (cfg_mode != 2) begin
                    iq.delete();
                    if (cfg_mode == 1) iq.push_back(7);
                    for (int i = 0; i < cfg_n; i++) begin
                        iq.push_back(i);
                        if (cfg_mode == 1) iq.push_back(i);
                    end
                    repeat (cfg_lat) @(posedge clk);
                    #1;
                    bus.heap_done = 1'b1;
                    bus.heap_n = 10'(cfg_n);
                    streaming = 1'b1;
                    foreach (iq[k]) begin
                        @(posedge clk);
                        #1;
                        bus.heap_done = 1'b0;
                        bus.heap_index = 10'(iq[k]);
                        bus.heap_arr_out = (iq[k] < cfg_n) ? dat(iq[k]) : 32'hDEAD;
                    end
                    @(posedge clk);
                    #1;
                    bus.heap_done = 1'b0;
                    bus.heap_index = '1;
                    streaming = 1'b0;
                end
            end
        end
    end

    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.rsp_ready = tgl ? !bus.rsp_ready : 1'b1;
        end
    end

    // Beat collector with hold-while-stalled checking
    initial begin
        logic p_stall, p_l, p_e;
        logic [31:0] p_d;
        p_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && p_stall) begin
                chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
                chk("hold_data", bus.rsp_data, p_d);
                chk("hold_flags", {30'd0, bus.rsp_last, bus.rsp_empty}, {30'd0, p_l, p_e});
            end
            if (!reset && bus.rsp_valid && bus.rsp_ready) begin
                bq_d.push_back(bus.rsp_data);
                bq_l.push_back(bus.rsp_last);
                bq_e.push_back(bus.rsp_empty);
                beat_total++;
            end
            p_stall = !reset && bus.rsp_valid && !bus.rsp_ready;
            p_d = bus.rsp_data;
            p_l = bus.rsp_last;
            p_e = bus.rsp_empty;
        end
    end

    task automatic bound_fail(input string nm);
        checks++;
        fails++;
        $display("FAIL %s actual=timeout required=completion", nm);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int s0;
        bit ok;
        logic [31:0] ed;
        cfg_n = v.n;
        cfg_lat = v.lat;
        cfg_mode = v.mode;
        cfg_pat = v.pat;
        cfg_base = v.base;
        tgl = v.tgl;
        bq_d.delete();
        bq_l.delete();
        bq_e.delete();
        s0 = st_op.size();
        bus.cmd_op = v.op;
        bus.cmd_key = v.key;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        ok = 0;
        for (int c = 0; c < 6000 && !ok; c++) begin
            @(negedge clk);
            ok = st_op.size() > s0 && !busy;
        end
        if (!ok) bound_fail($sformatf("v%0d_wait", id));
        tgl = 0;
        chk($sformatf("v%0d_starts", id), 32'(st_op.size() - s0), 32'd1);
        if (st_op.size() > s0) begin
            chk($sformatf("v%0d_op", id), 32'(st_op[s0]), 32'(v.op));
            if (!v.op) chk($sformatf("v%0d_key", id), st_key[s0], v.key);
        end
        chk($sformatf("v%0d_beats", id), 32'(bq_d.size()), 32'(v.e_beats));
        for (int j = 0; j < v.e_beats && j < bq_d.size(); j++) begin
            ed = (v.n == 0) ? 32'd0 : (v.pat == 1) ? pat3[j] : v.base - 32'(j);
            chk($sformatf("v%0d_data%0d", id, j), bq_d[j], ed);
            chk($sformatf("v%0d_last%0d", id, j), 32'(bq_l[j]), 32'(j == v.e_beats - 1));
            chk($sformatf("v%0d_empty%0d", id, j), 32'(bq_e[j]), 32'(v.n == 0));
        end
        chk($sformatf("v%0d_err_trunc", id), 32'(err_tr), 32'(v.e_tr));
        chk($sformatf("v%0d_err_timeout", id), 32'(err_to), 32'(v.e_to));
        chk($sformatf("v%0d_cmd_ready", id), 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        int s0, b0;
        bit ok;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 1'b0;
        bus.cmd_key = '0;
        //           op    key     n   lat mode tgl pat base    beats tr    to
        vecs[0] = '{1'b0, 32'd15, 11, 5,  0,  1'b0, 0, 32'd500, 11, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'd0,  10, 2,  0,  1'b1, 0, 32'd300, 10, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'd0,  3,  1,  1,  1'b0, 1, 32'd0,   3,  1'b0, 1'b0};
        vecs[3] = '{1'b0, 32'd7,  0,  3,  0,  1'b0, 0, 32'd0,   1,  1'b0, 1'b0};
        vecs[4] = '{1'b0, 32'd99, 20, 2,  0,  1'b1, 0, 32'd800, 16, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 32'd0,  5,  1,  2,  1'b0, 0, 32'd0,   0,  1'b1, 1'b1};
        vecs[6] = '{1'b0, 32'd42, 4,  1,  0,  1'b0, 0, 32'd50,  4,  1'b1, 1'b1};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_start", 32'(bus.heap_start), 32'd0);
        chk("rst_rsp", {29'd0, bus.rsp_valid, bus.rsp_last, bus.rsp_empty}, 32'd0);
        chk("rst_heap_key", bus.heap_key, 32'd0);
        chk("rst_errs", {30'd0, err_to, err_tr}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int v = 0; v < 7; v++) run_vec(vecs[v], v);

        // Back-to-back: five writes, the first is popped, the remaining four fill the FIFO
        cfg_n = 2;
        cfg_lat = 3;
        cfg_mode = 0;
        cfg_pat = 0;
        cfg_base = 32'd900;
        s0 = st_op.size();
        b0 = beat_total;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("b2b_ready%0d", i), 32'(bus.cmd_ready), 32'd1);
            bus.cmd_valid = 1'b1;
            bus.cmd_op = 1'b0;
            bus.cmd_key = 32'(11 + i);
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        chk("b2b_full", 32'(bus.cmd_ready), 32'd0);
        ok = 0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            ok = st_op.size() >= s0 + 5 && !busy;
        end
        if (!ok) bound_fail("b2b_wait");
        chk("b2b_starts", 32'(st_op.size() - s0), 32'd5);
        for (int k = 0; k < 5 && s0 + k < st_op.size(); k++) begin
            chk($sformatf("b2b_key%0d", k), st_key[s0 + k], 32'(11 + k));
            chk($sformatf("b2b_order%0d", k), 32'(st_bt[s0 + k] - b0), 32'(2 * k));
        end
        chk("b2b_beats", 32'(beat_total - b0), 32'd10);

        // Reset while capturing clears everything including sticky errors
        cfg_n = 10;
        cfg_lat = 1;
        cfg_base = 32'd70;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b1;
        bus.cmd_key = 32'd5;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            ok = streaming;
        end
        if (!ok) bound_fail("cap_wait");
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("cap_rst_busy", 32'(busy), 32'd0);
        chk("cap_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("cap_rst_rsp", {29'd0, bus.rsp_valid, bus.rsp_last, bus.rsp_empty}, 32'd0);
        chk("cap_rst_heap_key", bus.heap_key, 32'd0);
        chk("cap_rst_errs", {30'd0, err_to, err_tr}, 32'd0);
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Reset landing on the ISSUE cycle must suppress the start pulse
        s0 = st_op.size();
        bus.cmd_valid = 1'b1;
        bus.cmd_key = 32'd6;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("iss_rst_start", 32'(bus.heap_start), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("iss_rst_nostart", 32'(st_op.size() - s0), 32'd0);
        chk("iss_rst_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
